i2c_target_regfile: RTL and testbench

- Parametrised I2C target (slave) with an integrated register file; next generation of the fixed-address, 32-register I2C datapath.
- Adds a configurable device address and register count, pointer-validated auto-increment with wrap, repeated-START handling, and a master-NACK read termination.
- Adds a local host write port and per-write strobes, so the surrounding design can both observe and update registers.
- Sits between the board-level SCL/SDA pins (via an open-drain pad) and the chip's control/status logic.

---
 rtl/i2c_target_regfile.sv | 251 +++++++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// I2C target (slave) with an integrated NUM_REGS x 8-bit register file, auto-increment pointer and host write port.
// Optional SCL-low bus timeout is compiled in when the macro I2C_TIMEOUT_EN is defined.

module i2c_target_regfile #(
    parameter logic [6:0] DEV_ADDR       = 7'h20,
    parameter int         NUM_REGS       = 32,
    parameter int         PTR_W          = 5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  SCL,
    input  logic                  SDA_in,
    output logic                  SDA_out,
    input  logic                  host_we,
    input  logic [PTR_W-1:0]      host_addr,
    input  logic [7:0]            host_wdata,
    output logic [8*NUM_REGS-1:0] regs_packed,
    output logic                  wr_strobe,
    output logic [PTR_W-1:0]      wr_addr,
    output logic                  busy
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_PTR       = 4'd3,
        S_PTR_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RDATA_ACK = 4'd8,
        S_WAIT_STOP = 4'd9
    } state_t;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (32'(p) == 32'(NUM_REGS - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    logic             r_scl_meta, r_scl_sync, r_scl_prev;
    logic             r_sda_meta, r_sda_sync, r_sda_prev;
    state_t           r_state;
    logic [3:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_tx;
    logic             r_rw;
    logic             r_mack;
    logic [PTR_W-1:0] r_ptr;
    logic             r_sda_out;
    logic             r_busy;
    logic             r_wr_strobe;
    logic [PTR_W-1:0] r_wr_addr;
    logic [7:0]       r_regs [NUM_REGS];

    logic             w_scl_rise, w_scl_fall, w_start, w_stop;
    logic             w_host_ok, w_ptr_ok, w_timeout;
    logic [PTR_W-1:0] w_ptr_inc;

    // Two-flop synchronisers plus one history flop per line for edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_meta <= SCL;
            r_scl_sync <= r_scl_meta;
            r_scl_prev <= r_scl_sync;
            r_sda_meta <= SDA_in;
            r_sda_sync <= r_sda_meta;
            r_sda_prev <= r_sda_sync;
        end
    end

    assign w_scl_rise = r_scl_sync & ~r_scl_prev;
    assign w_scl_fall = ~r_scl_sync & r_scl_prev;
    assign w_start    = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
    assign w_stop     = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;
    assign w_host_ok  = host_we && (32'(host_addr) < 32'(NUM_REGS));
    assign w_ptr_ok   = ({24'd0, r_shift} < 32'(NUM_REGS));
    assign w_ptr_inc  = ptr_next(r_ptr);

`ifdef I2C_TIMEOUT_EN
    logic [31:0] r_to_cnt;

    // Count consecutive low-SCL cycles while a transfer owns the bus
    always_ff @(posedge clock) begin
        if (reset || !r_busy || r_scl_sync) begin
            r_to_cnt <= 32'd0;
        end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end
    end

    assign w_timeout = r_busy && !r_scl_sync && (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Protocol FSM, register file and host port; an I2C commit overrides a same-cycle host write
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'd0;
            r_tx        <= 8'd0;
            r_rw        <= 1'b0;
            r_mack      <= 1'b1;
            r_ptr       <= {PTR_W{1'b0}};
            r_sda_out   <= 1'b1;
            r_busy      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= {PTR_W{1'b0}};
            for (int j = 0; j < NUM_REGS; j++) begin
                r_regs[j] <= 8'd0;
            end
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_host_ok) begin
                r_regs[host_addr] <= host_wdata;
            end
            if (w_stop || w_timeout) begin
                r_state   <= S_IDLE;
                r_sda_out <= 1'b1;
                r_busy    <= 1'b0;
                r_bit_cnt <= 4'd0;
            end else if (w_start) begin
                r_state   <= S_ADDR;
                r_sda_out <= 1'b1;
                r_bit_cnt <= 4'd0;
            end else if (w_scl_rise) begin
                case (r_state)
                    S_ADDR, S_PTR, S_WDATA: begin
                        if (r_bit_cnt < 4'd8) begin
                            r_shift   <= {r_shift[6:0], r_sda_sync};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    S_RDATA: begin
                        if (r_bit_cnt < 4'd8) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    S_RDATA_ACK: r_mack <= r_sda_sync;
                    default: ;
                endcase
            end else if (w_scl_fall) begin
                case (r_state)
                    S_ADDR: begin
                        if (r_bit_cnt == 4'd8) begin
                            r_bit_cnt <= 4'd0;
                            if (r_shift[7:1] == DEV_ADDR) begin
                                r_sda_out <= 1'b0;
                                r_busy    <= 1'b1;
                                r_rw      <= r_shift[0];
                                r_state   <= S_ADDR_ACK;
                            end else begin
                                r_sda_out <= 1'b1;
                                r_state   <= S_WAIT_STOP;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        // A read snapshots the addressed register at the edge that starts the byte
                        if (r_rw) begin
                            r_tx      <= {r_regs[r_ptr][6:0], 1'b0};
                            r_sda_out <= r_regs[r_ptr][7];
                            r_state   <= S_RDATA;
                        end else begin
                            r_sda_out <= 1'b1;
                            r_state   <= S_PTR;
                        end
                    end
                    S_PTR: begin
                        if (r_bit_cnt == 4'd8) begin
                            r_bit_cnt <= 4'd0;
                            if (w_ptr_ok) begin
                                r_sda_out <= 1'b0;
                                r_ptr     <= PTR_W'(r_shift);
                                r_state   <= S_PTR_ACK;
                            end else begin
                                r_sda_out <= 1'b1;
                                r_state   <= S_WAIT_STOP;
                            end
                        end
                    end
                    S_PTR_ACK: begin
                        r_sda_out <= 1'b1;
                        r_state   <= S_WDATA;
                    end
                    S_WDATA: begin
                        if (r_bit_cnt == 4'd8) begin
                            r_bit_cnt <= 4'd0;
                            r_sda_out <= 1'b0;
                            r_state   <= S_WDATA_ACK;
                        end
                    end
                    S_WDATA_ACK: begin
                        r_regs[r_ptr] <= r_shift;
                        r_wr_strobe   <= 1'b1;
                        r_wr_addr     <= r_ptr;
                        r_ptr         <= w_ptr_inc;
                        r_sda_out     <= 1'b1;
                        r_state       <= S_WDATA;
                    end
                    S_RDATA: begin
                        if (r_bit_cnt == 4'd8) begin
                            r_bit_cnt <= 4'd0;
                            r_sda_out <= 1'b1;
                            r_mack    <= 1'b1;
                            r_state   <= S_RDATA_ACK;
                        end else if (r_bit_cnt != 4'd0) begin
                            r_sda_out <= r_tx[7];
                            r_tx      <= {r_tx[6:0], 1'b0};
                        end
                    end
                    S_RDATA_ACK: begin
                        if (!r_mack) begin
                            r_ptr     <= w_ptr_inc;
                            r_tx      <= {r_regs[w_ptr_inc][6:0], 1'b0};
                            r_sda_out <= r_regs[w_ptr_inc][7];
                            r_state   <= S_RDATA;
                        end else begin
                            r_sda_out <= 1'b1;
                            r_state   <= S_WAIT_STOP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
        assign regs_packed[8*g +: 8] = r_regs[g];
    end

    assign SDA_out   = r_sda_out;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Self-checking bench for i2c_target_regfile: bit-banged I2C master, transaction-level register model,
// directed scenarios followed by randomized write/read/mismatch/host traffic.

module tb_i2c_target_regfile;

    localparam int NREG = 32;
    localparam int Q    = 5;

    logic            clock;
    logic            reset;
    logic            tb_scl;
    logic            tb_sda;
    logic            host_we;
    logic [4:0]      host_addr;
    logic [7:0]      host_wdata;
    logic            sda_out_w;
    logic [8*NREG-1:0] regs_w;
    logic            wr_strobe_w;
    logic [4:0]      wr_addr_w;
    logic            busy_w;
    logic            sda_bus;

    logic [7:0] m_regs [NREG];
    int         m_ptr;
    bit         chk_en = 1'b0;
    int         n_cmp  = 0;
    int         n_err  = 0;
    logic [4:0] q_wr [$];

    assign sda_bus = tb_sda & sda_out_w;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    i2c_target_regfile #(
        .DEV_ADDR(7'h20), .NUM_REGS(NREG), .PTR_W(5), .TIMEOUT_CYCLES(50)
    ) dut (
        .clock(clock), .reset(reset), .SCL(tb_scl), .SDA_in(sda_bus), .SDA_out(sda_out_w),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .regs_packed(regs_w), .wr_strobe(wr_strobe_w), .wr_addr(wr_addr_w), .busy(busy_w)
    );

    function automatic logic [8*NREG-1:0] m_pack();
        logic [8*NREG-1:0] p;
        for (int i = 0; i < NREG; i++) p[8*i +: 8] = m_regs[i];
        return p;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Per-cycle register file comparison and wr_strobe capture
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (wr_strobe_w) q_wr.push_back(wr_addr_w);
            if (chk_en) begin
                n_cmp++;
                if (regs_w !== m_pack()) begin
                    n_err++;
                    if (n_err < 20)
                        $display("FAIL regs_cycle at %0t: got %h expected %h", $time, regs_w, m_pack());
                end
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic bit_xfer(input logic b, output logic rb);
        wait_n(Q); tb_sda = b;
        wait_n(Q); tb_scl = 1'b1;
        wait_n(Q); rb = sda_bus;
        wait_n(Q); tb_scl = 1'b0;
    endtask

    task automatic i2c_start();
        wait_n(Q); tb_sda = 1'b1;
        wait_n(Q); tb_scl = 1'b1;
        wait_n(Q); tb_sda = 1'b0;
        wait_n(Q); tb_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_n(Q); tb_sda = 1'b0;
        wait_n(Q); tb_scl = 1'b1;
        wait_n(Q); tb_sda = 1'b1;
        wait_n(Q);
    endtask

    // Master writes one byte; commit=1 means the target must store it at the current model pointer
    task automatic wr_byte(input string nm, input logic [7:0] d, input logic exp_ack, input bit commit,
                           input bit inj, input logic [4:0] ha, input logic [7:0] hd);
        logic rb;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], rb);
        if (commit) chk_en = 1'b0;
        wait_n(Q); tb_sda = 1'b1;
        wait_n(Q); tb_scl = 1'b1;
        wait_n(Q); rb = sda_bus;
        wait_n(Q); tb_scl = 1'b0;
        check({nm, "_ack"}, rb, exp_ack ? 32'd0 : 32'd1);
        if (inj) begin
            wait_n(2);
            host_we = 1'b1; host_addr = ha; host_wdata = hd;
            wait_n(1);
            host_we = 1'b0;
            m_regs[ha] = hd;
        end
        if (commit) begin
            wait_n(6);
            m_regs[m_ptr] = d;
            check("strobe_cnt", q_wr.size(), 32'd1);
            if (q_wr.size() > 0) check("wr_addr", q_wr[0], m_ptr);
            q_wr.delete();
            m_ptr = (m_ptr + 1) % NREG;
            chk_en = 1'b1;
        end
    endtask

    task automatic rd_byte(input string nm, input logic [7:0] exp, input bit mack);
        logic [7:0] v;
        logic rb;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, rb);
            v[i] = rb;
        end
        bit_xfer(mack ? 1'b0 : 1'b1, rb);
        check(nm, v, exp);
    endtask

    task automatic finish_txn();
        i2c_stop();
        wait_n(4);
        check("busy_after_stop", busy_w, 32'd0);
        check("sda_released", sda_out_w, 32'd1);
        check("no_stray_strobe", q_wr.size(), 32'd0);
        q_wr.delete();
    endtask

    task automatic do_write(input int ptr, input int n, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3,
                            input bit inj, input logic [4:0] ha, input logic [7:0] hd);
        logic [7:0] d [4];
        bit ok;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        ok = (ptr < NREG);
        i2c_start();
        wr_byte("w_addr", 8'h40, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        check("busy_matched", busy_w, 32'd1);
        wr_byte("w_ptr", 8'(ptr), ok, 1'b0, 1'b0, 5'd0, 8'd0);
        if (ok) m_ptr = ptr;
        for (int k = 0; k < n; k++) wr_byte("w_data", d[k], ok, ok, inj && (k == 0), ha, hd);
        finish_txn();
    endtask

    task automatic do_read(input bit set_ptr, input int ptr, input int n);
        i2c_start();
        if (set_ptr) begin
            wr_byte("r_addr_w", 8'h40, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
            wr_byte("r_ptr", 8'(ptr), 1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
            m_ptr = ptr;
            i2c_start();
        end
        wr_byte("r_addr_r", 8'h41, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        check("busy_rd", busy_w, 32'd1);
        for (int k = 0; k < n; k++) begin
            rd_byte("rdata", m_regs[m_ptr], k < n - 1);
            if (k < n - 1) m_ptr = (m_ptr + 1) % NREG;
        end
        finish_txn();
    endtask

    task automatic do_mismatch(input logic [7:0] a);
        i2c_start();
        wr_byte("mm_addr", a, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
        wr_byte("mm_data", 8'($urandom), 1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
        check("mm_busy", busy_w, 32'd0);
        finish_txn();
    endtask

    task automatic host_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge clock);
        chk_en = 1'b0;
        host_we = 1'b1; host_addr = a; host_wdata = d;
        @(negedge clock);
        host_we = 1'b0;
        m_regs[a] = d;
        chk_en = 1'b1;
    endtask

    initial begin
        int kind;
        logic [7:0] ma;
        reset = 1'b1; tb_scl = 1'b1; tb_sda = 1'b1;
        host_we = 1'b0; host_addr = 5'd0; host_wdata = 8'd0;
        for (int i = 0; i < NREG; i++) m_regs[i] = 8'd0;
        m_ptr = 0;
        repeat (4) @(negedge clock);
        check("rst_sda", sda_out_w, 32'd1);
        check("rst_busy", busy_w, 32'd0);
        check("rst_strobe", wr_strobe_w, 32'd0);
        check("rst_wr_addr", wr_addr_w, 32'd0);
        check("rst_regs_zero", (regs_w == '0) ? 32'd1 : 32'd0, 32'd1);
        reset = 1'b0;
        wait_n(4);
        chk_en = 1'b1;

        do_write(3, 2, 8'hA5, 8'h5A, 8'h00, 8'h00, 1'b0, 5'd0, 8'd0);
        check("lit_reg3", regs_w[8*3 +: 8], 32'hA5);
        check("lit_reg4", regs_w[8*4 +: 8], 32'h5A);

        i2c_start();
        wr_byte("rs_addr_w", 8'h40, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        wr_byte("rs_ptr", 8'h03, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        m_ptr = 3;
        i2c_start();
        wr_byte("rs_addr_r", 8'h41, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        rd_byte("lit_rd_a5", 8'hA5, 1'b1);
        m_ptr = 4;
        rd_byte("lit_rd_5a", 8'h5A, 1'b0);
        finish_txn();
        i2c_start();
        wr_byte("cur_addr_r", 8'h41, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        rd_byte("lit_rd_ptr4", 8'h5A, 1'b0);
        finish_txn();

        do_mismatch(8'h42);

        do_write(31, 2, 8'h11, 8'h22, 8'h00, 8'h00, 1'b0, 5'd0, 8'd0);
        check("lit_reg31", regs_w[8*31 +: 8], 32'h11);
        check("lit_reg0", regs_w[8*0 +: 8], 32'h22);

        do_write(32, 2, 8'h77, 8'h88, 8'h00, 8'h00, 1'b0, 5'd0, 8'd0);

        do_write(5, 1, 8'h0F, 8'h00, 8'h00, 8'h00, 1'b1, 5'd5, 8'hFF);
        check("lit_coll_reg5", regs_w[8*5 +: 8], 32'h0F);
        do_write(5, 1, 8'h33, 8'h00, 8'h00, 8'h00, 1'b1, 5'd6, 8'h77);
        check("lit_reg5", regs_w[8*5 +: 8], 32'h33);
        check("lit_host_reg6", regs_w[8*6 +: 8], 32'h77);

        i2c_start();
        wr_byte("rr_addr_w", 8'h40, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        wr_byte("rr_ptr", 8'h04, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        i2c_start();
        wr_byte("rr_addr_r", 8'h41, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        wait_n(Q);
        check("rd_drive_msb", sda_out_w, 32'd0);
        chk_en = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrd_rst_sda", sda_out_w, 32'd1);
        check("midrd_rst_regs", (regs_w == '0) ? 32'd1 : 32'd0, 32'd1);
        check("midrd_rst_busy", busy_w, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < NREG; i++) m_regs[i] = 8'd0;
        m_ptr = 0;
        tb_sda = 1'b1;
        wait_n(Q);
        tb_scl = 1'b1;
        wait_n(10);
        q_wr.delete();
        chk_en = 1'b1;

        for (int t = 0; t < 24; t++) begin
            kind = int'($urandom_range(0, 4));
            case (kind)
                0, 1: do_write(int'($urandom_range(0, 35)), int'($urandom_range(1, 4)),
                               8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                               1'b0, 5'd0, 8'd0);
                2: do_read(1'b1, int'($urandom_range(0, 31)), int'($urandom_range(1, 3)));
                3: do_read(1'b0, 0, int'($urandom_range(1, 3)));
                default: begin
                    host_write(5'($urandom), 8'($urandom));
                    ma = 8'($urandom);
                    while (ma[7:1] == 7'h20) ma = 8'($urandom);
                    do_mismatch(ma);
                end
            endcase
        end

`ifdef I2C_TIMEOUT_EN
        i2c_start();
        wr_byte("to_addr", 8'h40, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        check("to_busy_before", busy_w, 32'd1);
        wait_n(60);
        check("to_busy_after", busy_w, 32'd0);
        check("to_sda", sda_out_w, 32'd1);
        finish_txn();
`endif

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
